instr_mem_loader: RTL and testbench

Instruction memory for the IF stage, with a byte-serial program loader. During load, bytes arrive from the debug/UART path and are packed into 32-bit words, written sequentially from word 0. During execution, the PC register's output addresses the array and the fetched word goes to the IF/ID path. Any unwritten or out-of-range location reads as the HALT encoding, so a runaway PC drives the pipeline into its end state instead of executing garbage.

---
 rtl/instr_mem_loader_pkg.sv | 15 +
 rtl/instr_mem_loader_byte_assembler.sv | 39 +++
 rtl/instr_mem_loader.sv | 110 +++++++++++
 tb/tb_instr_mem_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared IF-stage definitions: HALT encoding, loader states and width defaults.
package instr_mem_loader_pkg;

  localparam int unsigned WORD_WIDTH_DEF = 32;
  localparam int unsigned BYTE_WIDTH_DEF = 8;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    LD_IDLE = 2'b00,
    LD_BYTE = 2'b01,
    LD_DONE = 2'b10
  } ld_state_e;

endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// Packs MSB-first bytes into words; pulses o_word_valid on the byte that completes a word.
module byte_assembler
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int unsigned BYTE_WIDTH = BYTE_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_discard,
  input  logic                  i_accept,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  output logic                  o_word_valid,
  output logic [WORD_WIDTH-1:0] o_word
);

  localparam int unsigned BYTES_PER_WORD = WORD_WIDTH / BYTE_WIDTH;
  localparam int unsigned CNT_WIDTH      = $clog2(BYTES_PER_WORD);
  localparam int unsigned HELD_WIDTH     = WORD_WIDTH - BYTE_WIDTH;

  logic [CNT_WIDTH-1:0]  r_count;
  logic [HELD_WIDTH-1:0] r_held;
  logic                  w_last;

  assign w_last       = (r_count == CNT_WIDTH'(BYTES_PER_WORD - 1));
  assign o_word_valid = i_accept && !i_discard && w_last;
  // Only the earlier bytes are stored; the completing byte is merged straight from the input.
  assign o_word       = {r_held, i_byte};

  always_ff @(posedge i_clk) begin
    if (i_discard) begin
      r_count <= '0;
      r_held  <= '0;
    end else if (i_accept) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
      r_held  <= {r_held[HELD_WIDTH-BYTE_WIDTH-1:0], i_byte};
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with byte-serial loader; unwritten or out-of-range fetches return HALT.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int unsigned BYTE_WIDTH = BYTE_WIDTH_DEF,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int unsigned PC_WIDTH   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_load_en,
  input  logic                  i_byte_valid,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  input  logic [PC_WIDTH-1:0]   i_pc,
  output logic [WORD_WIDTH-1:0] o_instruction,
  output logic                  o_byte_ready,
  output logic                  o_load_done,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam logic [WORD_WIDTH-1:0] HALT_WORD  = WORD_WIDTH'(HALT_INSTR);
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(MEM_DEPTH);

  ld_state_e             r_state;
  ld_state_e             w_next_state;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic                  r_load_done;
  logic [WORD_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                  w_clear;
  logic                  w_full;
  logic                  w_byte_ready;
  logic                  w_accept;
  logic                  w_discard;
  logic                  w_word_valid;
  logic [WORD_WIDTH-1:0] w_word;
  logic [ADDR_WIDTH-1:0] w_rd_index;
  logic                  w_out_of_range;
  logic                  w_unused_pc_lsbs;

  assign w_clear      = i_reset || i_clear;
  assign w_full       = (r_word_count == FULL_COUNT);
  assign w_byte_ready = (r_state == LD_BYTE) && i_load_en && !w_full;
  assign w_accept     = i_byte_valid && w_byte_ready && !w_clear;
  assign w_discard    = w_clear || ((r_state == LD_BYTE) && !i_load_en);

  byte_assembler #(
    .WORD_WIDTH (WORD_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_byte_assembler (
    .i_clk        (i_clk),
    .i_discard    (w_discard),
    .i_accept     (w_accept),
    .i_byte       (i_byte),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LD_IDLE: if (i_load_en) w_next_state = LD_BYTE;
      LD_BYTE: begin
        if (!i_load_en) begin
          w_next_state = LD_IDLE;
        end else if (w_word_valid &&
                     ((w_word == HALT_WORD) || (r_word_count == FULL_COUNT - 1'b1))) begin
          w_next_state = LD_DONE;
        end
      end
      LD_DONE: w_next_state = LD_DONE;
      default: w_next_state = LD_IDLE;
    endcase
  end

  // Done flag trails the LD_DONE state by one edge.
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_state      <= LD_IDLE;
      r_word_count <= '0;
      r_load_done  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_load_done <= (r_state == LD_DONE);
      if (w_word_valid) r_word_count <= r_word_count + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_word_valid) r_mem[r_word_count[ADDR_WIDTH-1:0]] <= w_word;
  end

  assign w_rd_index       = i_pc[ADDR_WIDTH+1:2];
  assign w_out_of_range   = |i_pc[PC_WIDTH-1:ADDR_WIDTH+2];
  assign w_unused_pc_lsbs = ^i_pc[1:0];

  assign o_instruction = (w_out_of_range || ({1'b0, w_rd_index} >= r_word_count))
                         ? HALT_WORD : r_mem[w_rd_index];
  assign o_byte_ready  = w_byte_ready;
  assign o_load_done   = r_load_done;
  assign o_word_count  = r_word_count;
  assign o_empty       = (r_word_count == '0);
  assign o_full        = w_full;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Drives a 256-deep and a 4-deep loader with shared stimulus against a word-level model.
module tb_instr_mem_loader;

  logic        clk;
  logic        rst, clr, load_en, bv;
  logic [7:0]  byt;
  logic [31:0] pc;

  logic [31:0] instr0, instr1;
  logic        ready0, ready1, done0, done1, empty0, empty1, full0, full1;
  logic [8:0]  wc0;
  logic [2:0]  wc1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  instr_mem_loader dut (
    .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_load_en(load_en),
    .i_byte_valid(bv), .i_byte(byt), .i_pc(pc),
    .o_instruction(instr0), .o_byte_ready(ready0), .o_load_done(done0),
    .o_word_count(wc0), .o_empty(empty0), .o_full(full0)
  );

  instr_mem_loader #(.MEM_DEPTH(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_clear(clr), .i_load_en(load_en),
    .i_byte_valid(bv), .i_byte(byt), .i_pc(pc),
    .o_instruction(instr1), .o_byte_ready(ready1), .o_load_done(done1),
    .o_word_count(wc1), .o_empty(empty1), .o_full(full1)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // ---------------- behavioural model (index 0: depth 256, index 1: depth 4)
  int unsigned depth [2] = '{256, 4};
  bit          m_loading [2];
  bit          m_finished [2];
  int unsigned m_cnt [2];
  int unsigned m_nb [2];
  logic [31:0] m_part [2];
  logic [31:0] m_mem [2][256];
  int unsigned m_term [2];
  int unsigned edge_n = 0;

  always @(posedge clk) begin
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (rst || clr) begin
        m_loading[k] = 0; m_finished[k] = 0; m_cnt[k] = 0; m_nb[k] = 0;
      end else if (m_finished[k]) begin
        m_loading[k] = 0;
      end else if (!m_loading[k]) begin
        m_loading[k] = load_en;
      end else if (!load_en) begin
        m_loading[k] = 0; m_nb[k] = 0;
      end else if (bv && m_cnt[k] < depth[k]) begin
        m_part[k] = {m_part[k][23:0], byt};
        m_nb[k]++;
        if (m_nb[k] == 4) begin
          m_nb[k] = 0;
          m_mem[k][m_cnt[k]] = m_part[k];
          m_cnt[k]++;
          if (m_part[k] == 32'hFFFF_FFFF || m_cnt[k] == depth[k]) begin
            m_finished[k] = 1; m_loading[k] = 0; m_term[k] = edge_n;
          end
        end
      end
    end
  end

  function automatic logic [31:0] exp_instr(int k);
    int unsigned idx = pc >> 2;
    if (idx < m_cnt[k]) return m_mem[k][idx];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic exp_ready(int k);
    return m_loading[k] && load_en && (m_cnt[k] < depth[k]);
  endfunction

  function automatic logic exp_done(int k);
    return m_finished[k] && (edge_n > m_term[k]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("instr256", instr0, exp_instr(0));
      chk("ready256", 32'(ready0), 32'(exp_ready(0)));
      chk("done256",  32'(done0),  32'(exp_done(0)));
      chk("wc256",    32'(wc0),    m_cnt[0]);
      chk("empty256", 32'(empty0), 32'(m_cnt[0] == 0));
      chk("full256",  32'(full0),  32'(m_cnt[0] == 256));
      chk("instr4",   instr1, exp_instr(1));
      chk("ready4",   32'(ready1), 32'(exp_ready(1)));
      chk("done4",    32'(done1),  32'(exp_done(1)));
      chk("wc4",      32'(wc1),    m_cnt[1]);
      chk("empty4",   32'(empty1), 32'(m_cnt[1] == 0));
      chk("full4",    32'(full1),  32'(m_cnt[1] == 4));
    end
  end

  // ---------------- stimulus
  task automatic send(input logic [7:0] b);
    @(negedge clk); bv = 1; byt = b;
  endtask

  task automatic idle_cycle();
    @(negedge clk); bv = 0;
  endtask

  task automatic do_clear();
    @(negedge clk); clr = 1; load_en = 0; bv = 0;
    @(negedge clk); clr = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    send(t[31:24]); send(t[23:16]); send(t[15:8]); send(t[7:0]);
  endtask

  logic [7:0] prog [8] = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    rst = 1; clr = 0; load_en = 0; bv = 0; byt = 0; pc = 0;
    @(negedge clk); chk_en = 1;
    @(negedge clk); rst = 0; pc = 0;
    #1;
    chk("rst_instr_pc0",  instr0, 32'hFFFF_FFFF);
    chk("rst_empty",      32'(empty0), 32'd1);
    chk("rst_ready",      32'(ready0), 32'd0);
    chk("rst_done",       32'(done0),  32'd0);
    chk("rst_full",       32'(full0),  32'd0);
    pc = 32'h40; #1;
    chk("rst_instr_pc40", instr0, 32'hFFFF_FFFF);

    // two-word program ending in HALT
    @(negedge clk); load_en = 1; pc = 0;
    foreach (prog[i]) send(prog[i]);
    idle_cycle(); #1;
    chk("prog_wc",        32'(wc0),   32'd2);
    chk("prog_done_early",32'(done0), 32'd0);
    chk("prog_ready_done",32'(ready0),32'd0);
    @(negedge clk); #1;
    chk("prog_done",      32'(done0), 32'd1);
    pc = 0; #1;          chk("prog_pc0",    instr0, 32'h2001_0005);
    pc = 8; #1;          chk("prog_pc8",    instr0, 32'hFFFF_FFFF);
    pc = 3; #1;          chk("prog_pc3",    instr0, 32'h2001_0005);
    pc = 32'h1000; #1;   chk("prog_pc1000", instr0, 32'hFFFF_FFFF);

    // partial word discarded on load-enable drop
    do_clear(); #1;
    chk("clr_wc", 32'(wc0), 32'd0);
    load_en = 1; pc = 0;
    send(8'hAA); send(8'hBB);
    @(negedge clk); bv = 0; load_en = 0;
    @(negedge clk); load_en = 1;
    send(8'h8C); send(8'h22); send(8'h00); send(8'h04);
    idle_cycle(); #1;
    chk("abort_wc",   32'(wc0), 32'd1);
    chk("abort_word", instr0,   32'h8C22_0004);

    // clear on the same edge as the 4th byte
    do_clear();
    load_en = 1;
    send(8'h12); send(8'h34); send(8'h56);
    @(negedge clk); bv = 1; byt = 8'h78; clr = 1;
    @(negedge clk); clr = 0; bv = 0; #1;
    chk("clr4_wc",    32'(wc0),   32'd0);
    chk("clr4_ready", 32'(ready0),32'd0);
    chk("clr4_instr", instr0,     32'hFFFF_FFFF);

    // fill the 4-deep instance with non-HALT words
    do_clear();
    load_en = 1;
    for (int i = 1; i <= 16; i++) send(8'(i));
    @(negedge clk); bv = 1; byt = 8'h55; #1;
    chk("full4_full",  32'(full1),  32'd1);
    chk("full4_ready", 32'(ready1), 32'd0);
    chk("full4_wc",    32'(wc1),    32'd4);
    chk("full256_nf",  32'(full0),  32'd0);
    @(negedge clk); bv = 0; pc = 12; #1;
    chk("full4_done",  32'(done1),  32'd1);
    chk("full4_wc2",   32'(wc1),    32'd4);
    chk("full4_pc12",  instr1,      32'h0D0E_0F10);

    // HALT as the last word before full
    do_clear();
    load_en = 1;
    send_word(32'h1111_1111); send_word(32'h2222_2222);
    send_word(32'h3333_3333); send_word(32'hFFFF_FFFF);
    idle_cycle();
    @(negedge clk); #1;
    chk("halt4_full", 32'(full1), 32'd1);
    chk("halt4_done", 32'(done1), 32'd1);
    chk("halt256_done", 32'(done0), 32'd1);

    // randomized phase
    load_en = 0;
    for (int n = 0; n < 4000; n++) begin
      int unsigned r;
      @(negedge clk);
      r   = $urandom_range(0, 199);
      rst = (r == 0);
      clr = (r == 1) || (r == 2);
      if ($urandom_range(0, 99) < 3) load_en = ~load_en;
      if ($urandom_range(0, 99) < 2) load_en = 1;
      bv  = ($urandom_range(0, 3) != 0);
      byt = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      r   = $urandom_range(0, 99);
      if (r < 50)      pc = $urandom_range(0, 24);
      else if (r < 85) pc = $urandom_range(0, 1100);
      else             pc = $urandom;
    end

    @(negedge clk); rst = 0; clr = 0; bv = 0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
